// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-style part library.
// Holds the shift/storage register mode encoding and the default bus width.
package ttl_pkg;

  // Default register/bus width of the 74299-class part
  localparam int TTL_74299_WIDTH = 8;

  // Mode select encoding as seen on {S1,S0}
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } ttl_shift_mode_t;

  // Builds a mode value from the two select pins
  function automatic ttl_shift_mode_t ttl_decode_mode(input logic s1, input logic s0);
    return ttl_shift_mode_t'({s1, s0});
  endfunction

endpackage

// File: rtl/ttl_74299_bit.sv
// One storage cell of the 74299-class shift/storage register.
// A single flip-flop with a 4:1 next-state mux and an asynchronous clear.
// lower_nb is the value that moves in on a shift right (bit i-1 or DS0),
// upper_nb is the value that moves in on a shift left (bit i+1 or DS7).
module ttl_74299_bit
  import ttl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  ttl_shift_mode_t mode,
  input  logic            lower_nb,
  input  logic            upper_nb,
  input  logic            par_in,
  output logic            q
);

  // Clear wins over any edge; otherwise pick hold/shift/load by mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (mode)
        HOLD:    q <= q;
        SHR:     q <= lower_nb;
        SHL:     q <= upper_nb;
        LOAD:    q <= par_in;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/ttl_74299.sv
// 74299-class 8-bit universal shift/storage register with shared parallel bus.
// Build option: define TTL_74299_TRISTATE_EN to replace IO_I/IO_O/IO_OE with a
// single tristate inout IO bus; the default build keeps split ports.
module ttl_74299
  import ttl_pkg::*;
#(
  parameter int WIDTH = TTL_74299_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             S0,
  input  logic             S1,
  input  logic             DS0,
  input  logic             DS7,
  input  logic             _OE1,
  input  logic             _OE2,
`ifdef TTL_74299_TRISTATE_EN
  inout  wire  [WIDTH-1:0] IO,
`else
  input  logic [WIDTH-1:0] IO_I,
  output logic [WIDTH-1:0] IO_O,
  output logic             IO_OE,
`endif
  output logic             Q0,
  output logic             Q7
);

  ttl_shift_mode_t  mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] lower_vec;
  logic [WIDTH-1:0] upper_vec;
  logic [WIDTH-1:0] par_data;
  logic             drive_en;

  // Mode is sampled by every cell at the clock edge
  assign mode = ttl_decode_mode(S1, S0);

  // Bus is driven only with both enables low and never while loading
  assign drive_en = ~_OE1 & ~_OE2 & ~(S1 & S0);

  // Neighbour wiring: the serial inputs stand in for the missing end neighbours
  assign lower_vec = {q[WIDTH-2:0], DS0};
  assign upper_vec = {DS7, q[WIDTH-1:1]};

`ifdef TTL_74299_TRISTATE_EN
  assign IO       = drive_en ? q : {WIDTH{1'bz}};
  assign par_data = IO;
`else
  assign par_data = IO_I;
  assign IO_O     = q;
  assign IO_OE    = drive_en;
`endif

  // Serial outputs follow the end cells regardless of the enables
  assign Q0 = q[0];
  assign Q7 = q[WIDTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ttl_74299_bit u_bit (
      .clk      (CLK),
      .rst      (CLR),
      .mode     (mode),
      .lower_nb (lower_vec[i]),
      .upper_nb (upper_vec[i]),
      .par_in   (par_data[i]),
      .q        (q[i])
    );
  end

endmodule

// File: tb/tb_ttl_74299.sv
// Self-checking bench for ttl_74299 (default split-port build, WIDTH=8).
// Directed steps followed by randomized cycles, all checked against an
// arithmetic model of the register contents.
module tb_ttl_74299;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       s0 = 1'b0, s1 = 1'b0;
  logic       ds0 = 1'b0, ds7 = 1'b0;
  logic       oe1_n = 1'b0, oe2_n = 1'b0;
  logic [7:0] io_i = 8'h00;
  logic [7:0] io_o;
  logic       io_oe;
  logic       q0, q7;

  int         compared = 0;
  int         mismatched = 0;
  int         model_q = 0;

  ttl_74299 #(.WIDTH(8)) dut (
    .CLK   (clk),
    .CLR   (clr),
    .S0    (s0),
    .S1    (s1),
    .DS0   (ds0),
    .DS7   (ds7),
    ._OE1  (oe1_n),
    ._OE2  (oe2_n),
    .IO_I  (io_i),
    .IO_O  (io_o),
    .IO_OE (io_oe),
    .Q0    (q0),
    .Q7    (q7)
  );

  always #5 clk = ~clk;

  // Reference register update computed with plain arithmetic on the value
  function automatic int next_value(int cur, int mode, int d0, int d7, int par);
    case (mode)
      1:       return (cur * 2 + d0) % 256;
      2:       return cur / 2 + d7 * 128;
      3:       return par;
      default: return cur;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares every output against the model and the enable equation
  task automatic check_all(input string tag);
    logic [7:0] exp_q;
    logic       exp_oe;
    exp_q  = model_q[7:0];
    exp_oe = ~oe1_n & ~oe2_n & ~(s1 & s0);
    check({tag, ".io_o"}, io_o, exp_q);
    check({tag, ".q0"}, {7'b0, q0}, {7'b0, exp_q[0]});
    check({tag, ".q7"}, {7'b0, q7}, {7'b0, exp_q[7]});
    check({tag, ".io_oe"}, {7'b0, io_oe}, {7'b0, exp_oe});
  endtask

  // One clock edge: model follows the inputs held across the edge
  task automatic step(input string tag);
    @(posedge clk);
    if (clr) model_q = 0;
    else model_q = next_value(model_q, {s1, s0}, ds0, ds7, io_i);
    #1;
    check_all(tag);
  endtask

  task automatic set_mode(input logic [1:0] m);
    {s1, s0} = m;
  endtask

  initial begin
    // Reset state
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Preload A5, then clear mid-cycle
    set_mode(2'b11);
    io_i = 8'hA5;
    step("load_a5");
    check("load_a5_const", io_o, 8'hA5);
    #2;
    clr = 1'b1;
    model_q = 0;
    #1;
    check_all("clr_async");
    io_i = 8'hFF;
    step("clr_hold_load1");
    step("clr_hold_load2");

    // Edge while CLR still high is ignored; release just after it
    io_i = 8'h99;
    step("release_edge");
    clr = 1'b0;
    step("first_after_release");
    check("release_99", io_o, 8'h99);

    // Load then hold
    io_i = 8'h3C;
    step("load_3c");
    check("load_3c_oe", {7'b0, io_oe}, 8'h00);
    set_mode(2'b00);
    #1;
    check("hold_oe", {7'b0, io_oe}, 8'h01);
    for (int i = 0; i < 5; i++) step("hold");
    check("hold_3c", io_o, 8'h3C);

    // Shift right from 81, Q7 watched before each edge
    set_mode(2'b11);
    io_i = 8'h81;
    step("load_81");
    set_mode(2'b01);
    ds0 = 1'b0;
    ds7 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("shr_q7_pre", {7'b0, q7}, (i == 0 || i == 7) ? 8'h01 : 8'h00);
      step("shr");
    end
    check("shr_final", io_o, 8'h00);
    ds0 = 1'b1;
    step("shr_ds0");
    check("shr_01", io_o, 8'h01);

    // Shift left from 01 with DS7=1
    set_mode(2'b10);
    ds0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step("shl");
      if (i == 3) check("shl_e0", io_o, 8'hE0);
      if (i == 4) check("shl_f0", io_o, 8'hF0);
      check("shl_q0", {7'b0, q0}, (i == 8) ? 8'h01 : 8'h00);
    end

    // Output enables with Q=55
    set_mode(2'b11);
    io_i = 8'h55;
    step("load_55");
    set_mode(2'b00);
    oe1_n = 1'b1;
    #1;
    check_all("oe1_high");
    oe1_n = 1'b0;
    oe2_n = 1'b1;
    #1;
    check_all("oe2_high");
    oe2_n = 1'b0;
    #1;
    check_all("oe_both_low");
    check("oe_both_low_const", {7'b0, io_oe}, 8'h01);
    set_mode(2'b11);
    #1;
    check_all("oe_load_mode");
    check("oe_load_const", {7'b0, io_oe}, 8'h00);
    set_mode(2'b00);

    // Randomized cycles, including occasional clears
    for (int i = 0; i < 300; i++) begin
      {s1, s0} = 2'($urandom_range(0, 3));
      ds0   = 1'($urandom);
      ds7   = 1'($urandom);
      io_i  = 8'($urandom);
      oe1_n = ($urandom_range(0, 3) == 0);
      oe2_n = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      if (clr) model_q = 0;
      #1;
      check_all("rand_pre");
      step("rand");
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
